// File: rtl/cheriot_dv_pkg.sv
// cheriot_dv_pkg
// Shared DV types and constants for the CHERIoT DV top.
//   mem_cmd_t     : one completed memory access, as seen by the scoreboard/monitor
//   arb_state_e   : memory arbiter FSM state
//   DRAMStartAddr : lowest legal DRAM byte address
//   ArbLfsrSeed   : seed of the arbiter's optional back-pressure LFSR
package cheriot_dv_pkg;

    localparam logic [31:0] DRAMStartAddr = 32'h8000_0000;
    localparam logic [15:0] ArbLfsrSeed   = 16'hACE1;

    typedef struct packed {
        logic [7:0]  flag;    // {7'b0, requester id}
        logic        is_cap;
        logic        we;
        logic [3:0]  be;
        logic [29:0] addr32;
        logic [32:0] wdata;
        logic [32:0] rdata;   // zero for writes
        logic        err;
    } mem_cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2,
        DERR = 2'd3
    } arb_state_e;

endpackage

// File: rtl/cheriot_dv_stall_lfsr.sv
// cheriot_dv_stall_lfsr
// Free-running 16-bit Fibonacci LFSR (x^16 + x^14 + x^13 + x^11 + 1) used to inject
// random grant back-pressure in the memory arbiter. Advances every cycle.
//   clk     : clock
//   rst_n   : asynchronous active-low reset, loads ArbLfsrSeed
//   stall_o : high when the two low LFSR bits are zero (about one cycle in four)
module cheriot_dv_stall_lfsr
    import cheriot_dv_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    output logic stall_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        feedback;

    always_comb begin
        feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d   = {lfsr_q[14:0], feedback};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= ArbLfsrSeed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall_o = (lfsr_q[1:0] == 2'b00);

endmodule

// File: rtl/cheriot_dv_mem_arbiter.sv
// cheriot_dv_mem_arbiter
// Shares one DRAM memory-model port between the ifetch (id 0) and data (id 1) requesters.
// One transaction in flight at a time, round-robin arbitration in IDLE, responses routed
// back to the owner, one mem_cmd_t log record per completed access.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   req_i/gnt_o            : per-requester request / one-cycle grant pulse
//   we_i, be_i, is_cap_i,
//   addr_i, wdata_i        : per-requester command (wdata bit 32 is the tag)
//   rvalid_o, rdata_o,
//   err_o                  : response to the owner (rdata/err shared)
//   mem_*_o / mem_*_i      : downstream command and handshake/response
//   log_valid_o, log_cmd_o : completed-access record, the cycle after the response
// Optional feature: define CHERIOT_DV_MEM_ARB_STALL_EN for LFSR-driven grant back-pressure.
module cheriot_dv_mem_arbiter
    import cheriot_dv_pkg::*;
#(
    parameter int unsigned NREQ      = 2,
    parameter logic [31:0] DRAM_BASE = DRAMStartAddr
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NREQ-1:0]       req_i,
    output logic [NREQ-1:0]       gnt_o,
    input  logic [NREQ-1:0]       we_i,
    input  logic [NREQ-1:0][3:0]  be_i,
    input  logic [NREQ-1:0]       is_cap_i,
    input  logic [NREQ-1:0][31:0] addr_i,
    input  logic [NREQ-1:0][32:0] wdata_i,
    output logic [NREQ-1:0]       rvalid_o,
    output logic [32:0]           rdata_o,
    output logic                  err_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [29:0]           mem_addr32_o,
    output logic [32:0]           mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [32:0]           mem_rdata_i,
    input  logic                  mem_err_i,
    output logic                  log_valid_o,
    output mem_cmd_t              log_cmd_o
);

    localparam int unsigned IdW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e     state_q, state_d;
    logic [IdW-1:0] ptr_q, ptr_d;

    // Captured command of the transaction in flight
    logic [IdW-1:0] owner_q;
    logic           we_q;
    logic [3:0]     be_q;
    logic           is_cap_q;
    logic [29:0]    addr32_q;
    logic [32:0]    wdata_q;

    logic           log_valid_q;
    mem_cmd_t       log_cmd_q, log_cmd_d;

    logic           stall;
    logic           win_valid;
    logic [IdW-1:0] win_id;
    logic [IdW-1:0] idx;
    logic           capture;
    logic           resp_fire;

`ifdef CHERIOT_DV_MEM_ARB_STALL_EN
    cheriot_dv_stall_lfsr u_stall_lfsr (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .stall_o (stall)
    );
`else
    assign stall = 1'b0;
`endif

    // Round-robin pick: first requester at or after the pointer, wrapping.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = IdW'((32'(ptr_q) + i) % NREQ);
            if (!win_valid && req_i[idx]) begin
                win_valid = 1'b1;
                win_id    = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        capture   = 1'b0;
        resp_fire = 1'b0;
        gnt_o     = '0;
        rvalid_o  = '0;
        rdata_o   = '0;
        err_o     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A stalled cycle leaves the pointer alone so fairness is unaffected.
                if (win_valid && !stall) begin
                    gnt_o[win_id] = 1'b1;
                    capture       = 1'b1;
                    ptr_d         = IdW'((32'(win_id) + 32'd1) % NREQ);
                    state_d       = (addr_i[win_id] < DRAM_BASE) ? DERR : ADDR;
                end
            end
            ADDR: begin
                if (mem_gnt_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (mem_rvalid_i) begin
                    rvalid_o[owner_q] = 1'b1;
                    rdata_o           = mem_rdata_i;
                    err_o             = mem_err_i;
                    resp_fire         = 1'b1;
                    state_d           = IDLE;
                end
            end
            DERR: begin
                rvalid_o[owner_q] = 1'b1;
                err_o             = 1'b1;
                resp_fire         = 1'b1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        log_cmd_d        = '0;
        log_cmd_d.flag   = 8'(owner_q);
        log_cmd_d.is_cap = is_cap_q;
        log_cmd_d.we     = we_q;
        log_cmd_d.be     = be_q;
        log_cmd_d.addr32 = addr32_q;
        log_cmd_d.wdata  = wdata_q;
        log_cmd_d.rdata  = we_q ? 33'd0 : rdata_o;
        log_cmd_d.err    = err_o;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q  <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            is_cap_q <= 1'b0;
            addr32_q <= '0;
            wdata_q  <= '0;
        end else if (capture) begin
            owner_q  <= win_id;
            we_q     <= we_i[win_id];
            be_q     <= be_i[win_id];
            is_cap_q <= is_cap_i[win_id];
            addr32_q <= addr_i[win_id][31:2];
            wdata_q  <= wdata_i[win_id];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            log_valid_q <= 1'b0;
            log_cmd_q   <= '0;
        end else begin
            log_valid_q <= resp_fire;
            if (resp_fire) begin
                log_cmd_q <= log_cmd_d;
            end
        end
    end

    // Command outputs come straight from the capture registers, so they hold until mem_gnt_i.
    assign mem_req_o    = (state_q == ADDR);
    assign mem_we_o     = we_q;
    assign mem_be_o     = be_q;
    assign mem_addr32_o = addr32_q;
    assign mem_wdata_o  = wdata_q;

    assign log_valid_o  = log_valid_q;
    assign log_cmd_o    = log_cmd_q;

endmodule
